mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 115 +++++++++++
 tb/tb_mem_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-cache request per accepted load/store,
// waits for dhit, and hands the result to MEM/WB under wb_stall backpressure.
module mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] aluout_i,
  input  logic [DATA_W-1:0] wdat_i,
  input  logic              halt_i,
  input  logic              flush,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  input  logic              wb_stall,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [DATA_W-1:0] dload_o,
  output logic              out_valid,
  output logic              halt_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t            state;
  logic [DATA_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdat_p0;
  logic              rd_p0;
  logic              wr_p0;
  logic              flush_pend;
  logic              accept;
  logic              ld_only;
  logic              squash;

  assign mem_stall = (state != IDLE) | wb_stall;
  assign accept    = (state == IDLE) & in_valid & ~mem_stall & ~halt_o & ~flush;
  // A request marked both read and write is treated as a plain store.
  assign ld_only   = rd_p0 & ~wr_p0;
  assign squash    = flush | flush_pend;

  // Request outputs decode from registered state so reset drops them at once.
  assign dmemREN   = (state == ACCESS) & ld_only;
  assign dmemWEN   = (state == ACCESS) & wr_p0;
  assign dmemaddr  = addr_p0;
  assign dmemstore = wdat_p0;

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state      <= IDLE;
      addr_p0    <= '0;
      wdat_p0    <= '0;
      rd_p0      <= 1'b0;
      wr_p0      <= 1'b0;
      flush_pend <= 1'b0;
      dload_o    <= '0;
      out_valid  <= 1'b0;
      halt_o     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        // Capture stage: latch the request or retire a non-memory op.
        IDLE: begin
          if (accept) begin
            if (MemRead_i | MemWrite_i) begin
              addr_p0 <= aluout_i;
              wdat_p0 <= wdat_i;
              rd_p0   <= MemRead_i;
              wr_p0   <= MemWrite_i;
              state   <= ACCESS;
            end else begin
              out_valid <= 1'b1;
              if (halt_i) halt_o <= 1'b1;
            end
          end
        end
        // Access stage: the cache request cannot be aborted, so a flush only
        // suppresses the result once dhit arrives.
        ACCESS: begin
          if (dhit) begin
            flush_pend <= 1'b0;
            if (squash) begin
              state <= IDLE;
            end else begin
              if (ld_only) dload_o <= dmemload;
              if (wb_stall) begin
                state <= HOLD;
              end else begin
                out_valid <= 1'b1;
                state     <= IDLE;
              end
            end
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        // Hold stage: result waits for MEM/WB to free up.
        HOLD: begin
          if (flush) begin
            state <= IDLE;
          end else if (!wb_stall) begin
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: each instruction is described by its timing parameters
// and the expected per-cycle behaviour is derived from those parameters.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        in_valid = 0, MemRead_i = 0, MemWrite_i = 0;
  logic [31:0] aluout_i = '0, wdat_i = '0;
  logic        halt_i = 0, flush = 0, dhit = 0;
  logic [31:0] dmemload = '0;
  logic        wb_stall = 0;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        mem_stall;
  logic [31:0] dload_o;
  logic        out_valid, halt_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] dload_m = '0;
  bit          halted_m = 0;

  mem_stage #(.DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .aluout_i(aluout_i), .wdat_i(wdat_i),
    .halt_i(halt_i), .flush(flush), .dhit(dhit), .dmemload(dmemload),
    .wb_stall(wb_stall), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .dload_o(dload_o), .out_valid(out_valid), .halt_o(halt_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ren"}, {31'd0, dmemREN}, 32'd0);
    chk({tag, "_wen"}, {31'd0, dmemWEN}, 32'd0);
    chk({tag, "_addr"}, dmemaddr, 32'd0);
    chk({tag, "_store"}, dmemstore, 32'd0);
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_dload"}, dload_o, 32'd0);
    chk({tag, "_halt"}, {31'd0, halt_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
  endtask

  // One instruction presented at cycle 0. h = idle ACCESS cycles before dhit,
  // w = cycles wb_stall is high starting at the dhit cycle, f = ACCESS cycle
  // carrying a flush (0 = none), fh = HOLD cycle carrying a flush (0 = none),
  // f0 = flush alongside the instruction itself.
  task automatic run_op(input string tag, input bit rd, input bit wr, input bit hlt,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] ldv,
                        input int h, input int w, input int f, input int fh, input bit f0);
    bit acc, mem, sq_a, sq_h, busy, in_acc;
    int hitc, outc, end_busy, last;
    acc  = !halted_m && !f0;
    mem  = rd | wr;
    hitc = h + 1;
    sq_a = acc && mem && f >= 1 && f <= hitc;
    sq_h = acc && mem && !sq_a && w > 0 && fh >= 1 && fh <= w;
    outc = -1; end_busy = 0; last = 1;
    if (acc && !mem) begin
      outc = 1; last = 2;
    end else if (acc && mem) begin
      if (sq_a)      end_busy = hitc;
      else if (sq_h) end_busy = hitc + fh;
      else begin
        end_busy = hitc + w;
        outc     = hitc + w + 1;
      end
      last = end_busy + 1 + ((outc > 0) ? 1 : 0);
    end
    for (int c = 0; c <= last; c++) begin
      @(negedge CLK);
      busy   = acc && mem && c >= 1 && c <= end_busy;
      in_acc = acc && mem && c >= 1 && c <= hitc;
      if (c == 0) begin
        in_valid = 1; MemRead_i = rd; MemWrite_i = wr; halt_i = hlt;
        aluout_i = a; wdat_i = d; flush = f0; wb_stall = 0;
        dhit = 1'($urandom);
      end else begin
        in_valid   = busy ? 1'($urandom) : 1'b0;
        MemRead_i  = 1'($urandom);
        MemWrite_i = 1'($urandom);
        halt_i     = busy ? 1'($urandom) : 1'b0;
        aluout_i   = $urandom;
        wdat_i     = $urandom;
        flush      = (acc && mem && c == f && sq_a) || (sq_h && c == hitc + fh);
        if (in_acc && c < hitc)       dhit = 1'b0;
        else if (in_acc)              dhit = 1'b1;
        else                          dhit = busy ? 1'($urandom) : 1'b0;
        if (sq_a && in_acc)           wb_stall = 1'($urandom);
        else if (in_acc && c < hitc)  wb_stall = 1'($urandom);
        else                          wb_stall = (busy && c >= hitc && c < hitc + w);
      end
      dmemload = (in_acc && c == hitc) ? ldv : $urandom;
      #1;
      if (acc && mem && rd && !wr && !sq_a && c == hitc + 1) dload_m = ldv;
      if (acc && !mem && hlt && c == 1) halted_m = 1;
      chk({tag, "_ren"}, {31'd0, dmemREN}, {31'd0, in_acc && rd && !wr});
      chk({tag, "_wen"}, {31'd0, dmemWEN}, {31'd0, in_acc && wr});
      if (in_acc) begin
        chk({tag, "_addr"}, dmemaddr, a);
        chk({tag, "_store"}, dmemstore, d);
      end
      chk({tag, "_stall"}, {31'd0, mem_stall}, {31'd0, busy || wb_stall});
      chk({tag, "_ov"}, {31'd0, out_valid}, {31'd0, c == outc});
      chk({tag, "_dload"}, dload_o, dload_m);
      chk({tag, "_halt"}, {31'd0, halt_o}, {31'd0, halted_m});
    end
  endtask

  initial begin
    bit rd, wr;
    int h, w, f, fh;
    #1;
    chk_reset_outputs("reset");
    @(negedge CLK);
    nRST = 0;

    run_op("load",      1, 0, 0, 32'h40, 32'h0, 32'hDEADBEEF, 2, 0, 0, 0, 0);
    run_op("store_wbs", 0, 1, 0, 32'h80, 32'h12345678, 32'h55555555, 0, 2, 0, 0, 0);
    run_op("flush_ld",  1, 0, 0, 32'h44, 32'h0, 32'hAAAAAAAA, 3, 0, 2, 0, 0);
    run_op("nomem_a",   0, 0, 0, 32'h1, 32'h2, 32'h0, 0, 0, 0, 0, 0);
    run_op("nomem_b",   0, 0, 0, 32'h3, 32'h4, 32'h0, 0, 0, 0, 0, 0);
    run_op("flush_idle",1, 0, 0, 32'h48, 32'h0, 32'h11111111, 0, 0, 0, 0, 1);
    run_op("flush_hold",1, 0, 0, 32'h4C, 32'h0, 32'h22222222, 1, 2, 0, 1, 0);
    run_op("rd_wr",     1, 1, 0, 32'h50, 32'hCAFEF00D, 32'h33333333, 1, 0, 0, 0, 0);
    run_op("ld_wbs",    1, 0, 0, 32'h54, 32'h0, 32'h44444444, 0, 1, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom); wr = 1'($urandom);
      h  = $urandom_range(0, 3);
      w  = $urandom_range(0, 2);
      f  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, h + 1) : 0;
      fh = (w > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, w) : 0;
      run_op("rand", rd, wr, 0, $urandom, $urandom, $urandom, h, w, f, fh,
             ($urandom_range(0, 7) == 0));
    end

    run_op("halt",      0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    run_op("post_halt", 1, 0, 0, 32'h60, 32'h0, 32'h66666666, 0, 0, 0, 0, 0);

    @(negedge CLK);
    nRST = 1;
    #1;
    chk_reset_outputs("halt_clr");
    @(negedge CLK);
    nRST = 0; halted_m = 0; dload_m = '0;

    // Reset asserted mid-cycle while a load is outstanding.
    run_op("pre_rst",   1, 0, 0, 32'h70, 32'h0, 32'h77777777, 0, 0, 0, 0, 0);
    @(negedge CLK);
    in_valid = 1; MemRead_i = 1; MemWrite_i = 0; halt_i = 0; flush = 0;
    aluout_i = 32'h100; wdat_i = 32'h0; dhit = 0; wb_stall = 0;
    @(negedge CLK);
    in_valid = 0;
    #1;
    chk("rst_acc_ren", {31'd0, dmemREN}, 32'd1);
    chk("rst_acc_addr", dmemaddr, 32'h100);
    #2;
    nRST = 1;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge CLK);
    nRST = 0; dload_m = '0;

    run_op("after_rst", 1, 0, 0, 32'h104, 32'h0, 32'h89ABCDEF, 1, 1, 0, 0, 0);
    run_op("after_st",  0, 1, 0, 32'h108, 32'h0BADF00D, 32'h0, 2, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
